// File: rtl/pkg_dtypes.sv
// Shared types for the interconnect operand fetcher.
package pkg_dtypes;

  localparam int unsigned FETCH_ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } type_fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
  } type_fetch_req;

endpackage

// File: rtl/icon_fetch_fifo.sv
// In-order request queue of operand tags; exposes head, next-after-head and occupancy.
module icon_fetch_fifo #(
  parameter int unsigned LOG2_DEPTH = 2,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count,
  output logic [ADDR_W-1:0]     head,
  output logic [ADDR_W-1:0]     head_next
);

  localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

  logic [ADDR_W-1:0]     mem [DEPTH];
  logic [LOG2_DEPTH:0]   wr_ptr_q, rd_ptr_q;
  logic [LOG2_DEPTH-1:0] rd_idx, rd_next_idx;
  logic                  push_en, pop_en;

  assign rd_idx      = rd_ptr_q[LOG2_DEPTH-1:0];
  assign rd_next_idx = rd_idx + LOG2_DEPTH'(1);

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                   (wr_ptr_q[LOG2_DEPTH-1:0] == rd_idx);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign head      = mem[rd_idx];
  assign head_next = mem[rd_next_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q[LOG2_DEPTH-1:0]] <= push_addr;
  end

endmodule

// File: rtl/icon_operand_fetcher.sv
// Operand fetcher: queues tags, retries producer reads until hit, delivers to consumer.
// Optional retry timeout enabled by defining ICON_FETCH_TIMEOUT_EN.
module icon_operand_fetcher
  import pkg_dtypes::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LOG2_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic              src_req_valid_o,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic              src_success_i,
  output logic              dst_valid_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] dst_data_o,
  input  logic              dst_ready_i,
  output logic              busy_o,
  output logic              timeout_err_o
);

  type_fetch_state_e   state_q, state_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_W-1:0]   dst_addr_q;
  logic [DATA_W-1:0]   dst_data_q;
  logic                load_src, capture, pop;
  logic                timeout_hit;

  logic                fifo_full, fifo_empty;
  logic [LOG2_DEPTH:0] fifo_count;
  logic [ADDR_W-1:0]   fifo_head, fifo_head_next;

  icon_fetch_fifo #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid_i),
    .push_addr (req_addr_i),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head),
    .head_next (fifo_head_next)
  );

`ifdef ICON_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] retry_q;
  logic             timeout_q;

  assign timeout_hit   = (state_q == FETCH) && !src_success_i &&
                         (retry_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err_o = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (load_src) retry_q <= '0;
      else if ((state_q == FETCH) && !src_success_i && (retry_q != '1)) retry_q <= retry_q + 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    load_src   = 1'b0;
    capture    = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = FETCH;
          load_src = 1'b1;
          src_addr_d = fifo_head;
        end
      end
      FETCH: begin
        if (src_success_i) begin
          capture = 1'b1;
          state_d = DELIVER;
        end else if (timeout_hit) begin
          pop = 1'b1;
        end
      end
      DELIVER: begin
        if (dst_ready_i) pop = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Retiring the head: the entry behind it (if already queued) is fetched immediately.
    if (pop) begin
      if (fifo_count > (LOG2_DEPTH + 1)'(1)) begin
        state_d    = FETCH;
        load_src   = 1'b1;
        src_addr_d = fifo_head_next;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      if (capture) begin
        dst_addr_q <= src_addr_q;
        dst_data_q <= src_data_i;
      end
    end
  end

  assign req_ready_o     = !fifo_full;
  assign src_addr_o      = src_addr_q;
  assign src_req_valid_o = (state_q == FETCH);
  assign dst_valid_o     = (state_q == DELIVER);
  assign dst_addr_o      = dst_addr_q;
  assign dst_data_o      = dst_data_q;
  assign busy_o          = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_icon_operand_fetcher.sv
// Directed and randomized bench for icon_operand_fetcher against a queue-based model.
module tb_icon_operand_fetcher;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int LOG2_DEPTH = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic              req_ready_o;
  logic [ADDR_W-1:0] src_addr_o;
  logic              src_req_valid_o;
  logic [DATA_W-1:0] src_data_i;
  logic              src_success_i = 1'b0;
  logic              dst_valid_o;
  logic [ADDR_W-1:0] dst_addr_o;
  logic [DATA_W-1:0] dst_data_o;
  logic              dst_ready_i = 1'b0;
  logic              busy_o;
  logic              timeout_err_o;

  logic [DATA_W-1:0] prod_mem [64];
  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] got_q [$];
  int checks = 0;
  int errors = 0;
  int fail_run = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  always #5 clk = ~clk;

  // Producer register file: read data is whatever the addressed entry holds.
  assign src_data_i = prod_mem[src_addr_o];

  icon_operand_fetcher #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .LOG2_DEPTH     (LOG2_DEPTH),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid_i),
    .req_addr_i      (req_addr_i),
    .req_ready_o     (req_ready_o),
    .src_addr_o      (src_addr_o),
    .src_req_valid_o (src_req_valid_o),
    .src_data_i      (src_data_i),
    .src_success_i   (src_success_i),
    .dst_valid_o     (dst_valid_o),
    .dst_addr_o      (dst_addr_o),
    .dst_data_o      (dst_data_o),
    .dst_ready_i     (dst_ready_i),
    .busy_o          (busy_o),
    .timeout_err_o   (timeout_err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready_o, 1);
    check({tag, "_srcv"}, src_req_valid_o, 0);
    check({tag, "_srca"}, src_addr_o, 0);
    check({tag, "_dstv"}, dst_valid_o, 0);
    check({tag, "_dsta"}, dst_addr_o, 0);
    check({tag, "_dstd"}, dst_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_tmo"}, timeout_err_o, 0);
  endtask

  task automatic push_one(input logic [ADDR_W-1:0] a);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    step();
    req_valid_i = 1'b0;
  endtask

  // One random cycle: pick inputs, compare against the queue model, then advance.
  task automatic rnd_cycle(input bit allow_push);
    bit push_ok;
    req_valid_i   = allow_push && ($urandom_range(0, 99) < 50);
    req_addr_i    = ADDR_W'($urandom_range(0, 63));
    src_success_i = !allow_push || ($urandom_range(0, 99) < 70) || (fail_run >= 5);
    dst_ready_i   = !allow_push || ($urandom_range(0, 99) < 70);
    check("rnd_ready", req_ready_o, exp_q.size() < DEPTH);
    check("rnd_busy", busy_o, exp_q.size() != 0);
    check("rnd_excl", src_req_valid_o & dst_valid_o, 0);
    if (src_req_valid_o) begin
      check("rnd_src_nonempty", exp_q.size() > 0, 1);
      check("rnd_src_addr", src_addr_o, exp_q[0]);
      fail_run = src_success_i ? 0 : fail_run + 1;
    end
    if (dst_valid_o) begin
      check("rnd_dst_addr", dst_addr_o, exp_q[0]);
      check("rnd_dst_data", dst_data_o, prod_mem[exp_q[0]]);
    end
    push_ok = req_valid_i && (exp_q.size() < DEPTH);
    if (dst_valid_o && dst_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
    if (push_ok) exp_q.push_back(req_addr_i);
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prod_mem[i] = $urandom;
    prod_mem[5] = 32'hDEADBEEF;

    // Reset state
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #2;
    check_reset_outputs("rst");

    // Immediate success, consumer ready: delivery two cycles after the push
    src_success_i = 1'b1;
    dst_ready_i   = 1'b1;
    push_one(6'h05);
    check("t1_idle_srcv", src_req_valid_o, 0);
    check("t1_busy", busy_o, 1);
    step();
    check("t1_fetch_srcv", src_req_valid_o, 1);
    check("t1_fetch_addr", src_addr_o, 6'h05);
    step();
    check("t1_dstv", dst_valid_o, 1);
    check("t1_dsta", dst_addr_o, 6'h05);
    check("t1_dstd", dst_data_o, 32'hDEADBEEF);
    check("t1_srcv_deliver", src_req_valid_o, 0);
    step();
    check("t1_done_dstv", dst_valid_o, 0);
    check("t1_done_busy", busy_o, 0);

    // Three misses then a hit: request held four cycles on the same tag
    src_success_i = 1'b0;
    push_one(6'h0A);
    step();
    for (int c = 0; c < 4; c++) begin
      check("t2_srcv_hold", src_req_valid_o, 1);
      check("t2_addr_hold", src_addr_o, 6'h0A);
      check("t2_no_dstv", dst_valid_o, 0);
      if (c < 3) step();
    end
    src_success_i = 1'b1;
    step();
    check("t2_dstv", dst_valid_o, 1);
    check("t2_dsta", dst_addr_o, 6'h0A);
    check("t2_dstd", dst_data_o, prod_mem[6'h0A]);
    step();
    check("t2_done", busy_o, 0);

    // Fill the queue; fifth request must be held off
    src_success_i = 1'b0;
    dst_ready_i   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("t3_ready_before", req_ready_o, 1);
      push_one(ADDR_W'(i));
    end
    req_valid_i = 1'b1;
    req_addr_i  = 6'h05;
    for (int c = 0; c < 3; c++) begin
      check("t3_full_ready", req_ready_o, 0);
      step();
    end
    req_valid_i   = 1'b0;
    src_success_i = 1'b1;
    dst_ready_i   = 1'b1;
    got_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (dst_valid_o) begin
        check("t3_data", dst_data_o, prod_mem[dst_addr_o]);
        got_q.push_back(dst_addr_o);
      end
      if (got_q.size() == 4 && !busy_o) break;
      step();
    end
    check("t3_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", (i < got_q.size()) ? got_q[i] : 6'h3F, i + 1);
    check("t3_idle", busy_o, 0);

    // Consumer stall: outputs frozen, no new source request
    src_success_i = 1'b1;
    dst_ready_i   = 1'b0;
    push_one(6'h11);
    step();
    step();
    hold_addr = dst_addr_o;
    hold_data = dst_data_o;
    check("t4_dsta", hold_addr, 6'h11);
    check("t4_dstd", hold_data, prod_mem[6'h11]);
    for (int c = 0; c < 5; c++) begin
      check("t4_dstv_hold", dst_valid_o, 1);
      check("t4_dsta_hold", dst_addr_o, hold_addr);
      check("t4_dstd_hold", dst_data_o, hold_data);
      check("t4_no_srcv", src_req_valid_o, 0);
      check("t4_busy", busy_o, 1);
      step();
    end
    dst_ready_i = 1'b1;
    step();
    check("t4_release", dst_valid_o, 0);
    check("t4_idle", busy_o, 0);

    // Reset while fetching with two more queued
    src_success_i = 1'b0;
    push_one(6'h21);
    push_one(6'h22);
    push_one(6'h23);
    check("t5_in_fetch", src_req_valid_o, 1);
    #2;
    reset = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    src_success_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("t5_no_dstv", dst_valid_o, 0);
      check("t5_no_srcv", src_req_valid_o, 0);
      check("t5_busy", busy_o, 0);
    end

    // Randomized traffic against the queue model
    exp_q.delete();
    fail_run = 0;
    for (int c = 0; c < 400; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !busy_o) break;
      rnd_cycle(1'b0);
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_idle", busy_o, 0);

`ifdef ICON_FETCH_TIMEOUT_EN
    // Producer never hits: entry dropped after eight retries, error sticky
    src_success_i = 1'b0;
    dst_ready_i   = 1'b1;
    push_one(6'h30);
    step();
    check("tmo_fetch", src_req_valid_o, 1);
    for (int c = 0; c < 8; c++) step();
    check("tmo_not_yet", timeout_err_o, 0);
    check("tmo_still_fetch", src_req_valid_o, 1);
    step();
    check("tmo_flag", timeout_err_o, 1);
    check("tmo_dropped", busy_o, 0);
    check("tmo_no_srcv", src_req_valid_o, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("tmo_no_dstv", dst_valid_o, 0);
      check("tmo_sticky", timeout_err_o, 1);
    end
`else
    check("tmo_tied", timeout_err_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
